// File: rtl/key_pkg.sv
// Shared types and constants for the pushbutton conditioning path.
// Imported by the per-channel key logic and by the multi-channel wrapper.
package key_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRESS = 3'd1,
        HOLD  = 3'd2,
        RPT   = 3'd3,
        REL   = 3'd4
    } key_state_t;

    localparam logic [1:0] KM_ONESHOT = 2'b00;
    localparam logic [1:0] KM_LEVEL   = 2'b01;
    localparam logic [1:0] KM_REPEAT  = 2'b10;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_channel.sv
// One pushbutton channel: 2-flop synchroniser, debounce filter and press FSM.
//
//   state | meaning
//   IDLE  | key released, waiting for a debounced press
//   PRESS | first cycle of a press, set pulses
//   HOLD  | key held, repeat timer running
//   RPT   | auto-repeat pulse cycle
//   REL   | one-cycle release pulse
module key_channel
    import key_pkg::*;
#(
    parameter int DEBOUNCE      = 4,
    parameter int REPEAT_DELAY  = 8,
    parameter int REPEAT_PERIOD = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       pressed_i,
    input  logic [1:0] mode_i,
    output logic       set_o,
    output logic       released_o,
    output logic       held_o
);

    localparam int TW = (max_int(REPEAT_DELAY, REPEAT_PERIOD) > 2)
                        ? $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD)) : 1;
    localparam logic [TW-1:0] LOAD_DELAY  = TW'(REPEAT_DELAY - 2);
    localparam logic [TW-1:0] LOAD_PERIOD = TW'(REPEAT_PERIOD - 2);

    logic sync1_q;
    logic sync2_q;
    logic held_w;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pressed_i;
            sync2_q <= sync1_q;
        end
    end

    generate
        if (DEBOUNCE == 0) begin : g_bypass
            assign held_w = sync2_q;
        end else begin : g_debounce
            localparam int CW = $clog2(DEBOUNCE + 1);
            localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;
            logic          held_q;
            logic          held_d;

            // Any cycle where the input agrees with the filtered level restarts the count.
            always_comb begin
                cnt_d  = '0;
                held_d = held_q;
                if (sync2_q != held_q) begin
                    if (cnt_q == CNT_LAST) begin
                        held_d = sync2_q;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            always_ff @(posedge Clock) begin
                if (Reset) begin
                    cnt_q  <= '0;
                    held_q <= 1'b0;
                end else begin
                    cnt_q  <= cnt_d;
                    held_q <= held_d;
                end
            end

            assign held_w = held_q;
        end
    endgenerate

    key_state_t    state_q;
    key_state_t    state_d;
    logic [TW-1:0] tmr_q;
    logic [TW-1:0] tmr_d;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        case (state_q)
            IDLE: begin
                if (held_w) state_d = PRESS;
            end
            PRESS: begin
                tmr_d   = LOAD_DELAY;
                state_d = held_w ? HOLD : REL;
            end
            HOLD: begin
                // Timer parks at zero so a later switch to repeat mode fires at once.
                if (!held_w) begin
                    state_d = REL;
                end else if (mode_i == KM_REPEAT && tmr_q == '0) begin
                    state_d = RPT;
                end else if (tmr_q != '0) begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            RPT: begin
                tmr_d   = LOAD_PERIOD;
                state_d = held_w ? HOLD : REL;
            end
            REL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        set_o      = 1'b0;
        released_o = 1'b0;
        case (state_q)
            PRESS:   set_o      = 1'b1;
            RPT:     set_o      = 1'b1;
            HOLD:    set_o      = (mode_i == KM_LEVEL);
            REL:     released_o = 1'b1;
            default: set_o      = 1'b0;
        endcase
    end

    assign held_o = held_w;

endmodule

// File: rtl/key_conditioner.sv
// Multi-channel pushbutton front end: one independent key_channel per KEY pin.
// Mode bits for channel i live at mode[2i+1:2i].
module key_conditioner
    import key_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int DEBOUNCE      = 4,
    parameter int REPEAT_DELAY  = 8,
    parameter int REPEAT_PERIOD = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [N_CH-1:0]   pressed,
    input  logic [2*N_CH-1:0] mode,
    output logic [N_CH-1:0]   set,
    output logic [N_CH-1:0]   released,
    output logic [N_CH-1:0]   held
);

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            key_channel #(
                .DEBOUNCE      (DEBOUNCE),
                .REPEAT_DELAY  (REPEAT_DELAY),
                .REPEAT_PERIOD (REPEAT_PERIOD)
            ) u_ch (
                .Clock      (Clock),
                .Reset      (Reset),
                .pressed_i  (pressed[i]),
                .mode_i     (mode[2*i +: 2]),
                .set_o      (set[i]),
                .released_o (released[i]),
                .held_o     (held[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with two channels; expectations are edge-indexed
// from the cycle where pressed is first sampled high (edge 0).
module tb_key_conditioner;
    import key_pkg::*;

    logic       Clock;
    logic       Reset;
    logic [1:0] pressed;
    logic [3:0] mode;
    logic [1:0] set;
    logic [1:0] released;
    logic [1:0] held;

    int checks = 0;
    int errors = 0;

    key_conditioner #(
        .N_CH          (2),
        .DEBOUNCE      (4),
        .REPEAT_DELAY  (8),
        .REPEAT_PERIOD (4)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .pressed  (pressed),
        .mode     (mode),
        .set      (set),
        .released (released),
        .held     (held)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past one rising edge and stop on the following falling edge.
    task automatic cyc();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic run_oneshot(input string name);
        mode[1:0]  = KM_ONESHOT;
        pressed[0] = 1'b1;
        for (int k = 0; k <= 35; k++) begin
            cyc();
            chk($sformatf("%s held0 k=%0d", name, k), 32'(held[0]), 32'(k >= 5 && k <= 24));
            chk($sformatf("%s set0 k=%0d", name, k), 32'(set[0]), 32'(k == 6));
            chk($sformatf("%s rel0 k=%0d", name, k), 32'(released[0]), 32'(k == 26));
            chk($sformatf("%s held1 k=%0d", name, k), 32'(held[1]), 32'(0));
            if (k == 19) pressed[0] = 1'b0;
        end
    endtask

    initial begin
        Reset   = 1'b1;
        pressed = 2'b11;
        mode    = 4'b0000;

        // 1: reset with keys held
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk($sformatf("rst set k=%0d", k), 32'(set), 32'(0));
            chk($sformatf("rst rel k=%0d", k), 32'(released), 32'(0));
            chk($sformatf("rst held k=%0d", k), 32'(held), 32'(0));
        end
        pressed = 2'b00;
        Reset   = 1'b0;
        cyc();
        chk("idle ch0", 32'(dut.g_ch[0].u_ch.state_q), 32'(IDLE));
        chk("idle ch1", 32'(dut.g_ch[1].u_ch.state_q), 32'(IDLE));
        chk("idle outs", 32'({set, released, held}), 32'(0));

        // 2: 3-cycle glitch is filtered
        pressed[0] = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            cyc();
            chk($sformatf("glitch k=%0d", k), 32'({set[0], released[0], held[0]}), 32'(0));
            if (k == 2) pressed[0] = 1'b0;
        end

        // 3: one-shot press
        run_oneshot("oneshot");

        // 4: auto-repeat
        mode[1:0]  = KM_REPEAT;
        pressed[0] = 1'b1;
        for (int k = 0; k <= 45; k++) begin
            cyc();
            chk($sformatf("rpt set0 k=%0d", k), 32'(set[0]),
                32'(k == 6 || (k >= 14 && k <= 34 && ((k - 14) % 4) == 0)));
            chk($sformatf("rpt rel0 k=%0d", k), 32'(released[0]), 32'(k == 36));
            chk($sformatf("rpt held0 k=%0d", k), 32'(held[0]), 32'(k >= 5 && k <= 34));
            if (k == 29) pressed[0] = 1'b0;
        end

        // 5: level mode on ch1, ch0 quiet
        mode       = {KM_LEVEL, KM_ONESHOT};
        pressed[1] = 1'b1;
        for (int k = 0; k <= 30; k++) begin
            cyc();
            chk($sformatf("lvl set1 k=%0d", k), 32'(set[1]), 32'(k >= 6 && k <= 20));
            chk($sformatf("lvl rel1 k=%0d", k), 32'(released[1]), 32'(k == 21));
            chk($sformatf("lvl held1 k=%0d", k), 32'(held[1]), 32'(k >= 5 && k <= 19));
            chk($sformatf("lvl ch0 k=%0d", k), 32'({set[0], released[0], held[0]}), 32'(0));
            if (k == 14) pressed[1] = 1'b0;
        end
        mode = 4'b0000;

        // 7: mode changes while held in HOLD with timer parked at zero
        pressed[0] = 1'b1;
        for (int k = 0; k <= 38; k++) begin
            cyc();
            chk($sformatf("mchg set0 k=%0d", k), 32'(set[0]),
                32'(k == 6 || k == 16 || k == 17 || k == 18 || k == 22 || k == 26));
            chk($sformatf("mchg rel0 k=%0d", k), 32'(released[0]), 32'(k == 30));
            if (k == 15) begin
                mode[1:0] = KM_LEVEL;
                #1;
                chk("mchg same-cycle level", 32'(set[0]), 32'(1));
            end
            if (k == 17) mode[1:0] = KM_REPEAT;
            if (k == 23) pressed[0] = 1'b0;
        end

        // 6: reset during HOLD in repeat mode, then a normal re-press
        mode[1:0]  = KM_REPEAT;
        pressed[0] = 1'b1;
        for (int k = 0; k <= 30; k++) begin
            cyc();
            if (k <= 9) begin
                chk($sformatf("rstmid set0 k=%0d", k), 32'(set[0]), 32'(k == 6));
                chk($sformatf("rstmid held0 k=%0d", k), 32'(held[0]), 32'(k >= 5));
                chk($sformatf("rstmid rel0 k=%0d", k), 32'(released[0]), 32'(0));
            end else begin
                chk($sformatf("rstmid zero k=%0d", k),
                    32'({set[0], released[0], held[0]}), 32'(0));
            end
            if (k == 9) begin
                Reset      = 1'b1;
                pressed[0] = 1'b0;
            end
            if (k == 11) Reset = 1'b0;
        end
        run_oneshot("repress");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
